// File: rtl/take_arbiter_pkg.sv
// rtl/take_arbiter_pkg.sv - shared types and helpers for take_arbiter
// Holds the FSM state enum, the requester-index width helper and the packed
// output word layout {eot, idx, payload} at the default widths.
package take_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    DRAIN
  } state_t;

  // Index width is max(1, clog2(num)) so a two-way arbiter still has a 1-bit index.
  function automatic int idx_width(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

  localparam int DEF_NUM   = 2;
  localparam int DEF_DIN_W = 16;
  localparam int DEF_CFG_W = 16;
  localparam int DEF_IDX_W = idx_width(DEF_NUM);

  typedef struct packed {
    logic                 eot;
    logic [DEF_IDX_W-1:0] idx;
    logic [DEF_DIN_W-1:0] payload;
  } dout_t;

endpackage

// File: rtl/dti.sv
// rtl/dti.sv - valid/ready take-style stream bundle
// Ports (modports):
//   producer : drives data, valid; samples ready
//   consumer : samples data, valid; drives ready
interface dti #(
  parameter int W = 8
) ();
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport producer (output data, output valid, input ready);
  modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick from an eligible vector
// Ports:
//   eligible  in  NUM    requesters that may be granted
//   last      in  IDX_W  most recently granted index; search starts at last+1
//   grant     out NUM    one-hot grant (all zero when nothing is eligible)
//   grant_idx out IDX_W  index of the granted requester
//   any       out 1      at least one requester is eligible
module rr_arbiter import take_arbiter_pkg::*; #(
  parameter int NUM = 2,
  localparam int IDX_W = idx_width(NUM)
) (
  input  logic [NUM-1:0]   eligible,
  input  logic [IDX_W-1:0] last,
  output logic [NUM-1:0]   grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;
  logic             hi_found;
  logic             lo_found;

  // Walking downward leaves the lowest eligible index above last in hi_idx and
  // the lowest eligible index overall in lo_idx; lo_idx is the wrap-around case.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_idx   = IDX_W'(i);
        lo_found = 1'b1;
        if (i > int'(last)) begin
          hi_idx   = IDX_W'(i);
          hi_found = 1'b1;
        end
      end
    end
  end

  assign any       = lo_found;
  assign grant_idx = hi_found ? hi_idx : lo_idx;
  assign grant     = any ? (NUM'(1) << grant_idx) : '0;

endmodule

// File: rtl/take_arbiter.sv
// rtl/take_arbiter.sv - round-robin sharing of one take stream among NUM requesters
// Ports:
//   clk   in        single clock, rising edge
//   rst   in        asynchronous active-high reset
//   cfg   consumer  [NUM] x CFG_W take count per requester transaction
//   din   consumer  [NUM] x (DIN_W+1) input streams, eot in the MSB
//   dout  producer  1+IDX_W+DIN_W packed {eot, idx, payload}
module take_arbiter import take_arbiter_pkg::*; #(
  parameter int NUM   = DEF_NUM,
  parameter int DIN_W = DEF_DIN_W,
  parameter int CFG_W = DEF_CFG_W
) (
  input  logic clk,
  input  logic rst,
  dti.consumer cfg [NUM],
  dti.consumer din [NUM],
  dti.producer dout
);

  localparam int IDX_W = idx_width(NUM);

  logic [CFG_W-1:0] cfg_data [NUM];
  logic [DIN_W:0]   din_data [NUM];
  logic [NUM-1:0]   cfg_valid;
  logic [NUM-1:0]   din_valid;
  logic [NUM-1:0]   cfg_ready;
  logic [NUM-1:0]   din_ready;
  logic [NUM-1:0]   cfg_zero;

  for (genvar i = 0; i < NUM; i++) begin : g_port
    assign cfg_data[i]  = cfg[i].data;
    assign cfg_valid[i] = cfg[i].valid;
    assign cfg_zero[i]  = (cfg[i].data == '0);
    assign cfg[i].ready = cfg_ready[i];
    assign din_data[i]  = din[i].data;
    assign din_valid[i] = din[i].valid;
    assign din[i].ready = din_ready[i];
  end

  state_t           state, state_nx;
  logic [IDX_W-1:0] g, g_nx;
  logic [IDX_W-1:0] last, last_nx;
  logic [CFG_W-1:0] cnt, cnt_nx;

  logic [NUM-1:0]   arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;

  rr_arbiter #(.NUM(NUM)) u_rr (
    .eligible  (cfg_valid & din_valid),
    .last      (last),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  logic [CFG_W-1:0] cur_cfg;
  logic [DIN_W:0]   cur_din;
  logic             cur_valid;
  logic             cur_eot;
  logic             eot_o;
  logic             out_valid;

  assign cur_cfg   = cfg_data[g];
  assign cur_din   = din_data[g];
  assign cur_valid = din_valid[g];
  assign cur_eot   = cur_din[DIN_W];
  // Truncation point: the take count is reached or the source ends first.
  assign eot_o     = ((cnt + CFG_W'(1)) == cur_cfg) || cur_eot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      g     <= '0;
      last  <= IDX_W'(NUM - 1);
      cnt   <= '0;
    end else begin
      state <= state_nx;
      g     <= g_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    g_nx      = g;
    last_nx   = last;
    cnt_nx    = cnt;
    out_valid = 1'b0;
    din_ready = '0;
    cfg_ready = '0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          g_nx     = arb_idx;
          last_nx  = arb_idx;
          cnt_nx   = '0;
          // A zero take count skips PASS so nothing of the transaction is forwarded.
          state_nx = |(arb_grant & cfg_zero) ? DRAIN : PASS;
        end
      end
      PASS: begin
        out_valid    = cur_valid;
        din_ready[g] = dout.ready;
        if (cur_valid && dout.ready) begin
          cnt_nx = cnt + CFG_W'(1);
          if (eot_o) begin
            if (cur_eot) begin
              cfg_ready[g] = 1'b1;
              state_nx     = IDLE;
            end else begin
              state_nx = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        din_ready[g] = 1'b1;
        if (cur_valid && cur_eot) begin
          cfg_ready[g] = 1'b1;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign dout.valid = out_valid;
  assign dout.data  = {eot_o, g, cur_din[DIN_W-1:0]};

endmodule

// File: tb/tb_take_arbiter.sv
// tb/tb_take_arbiter.sv - directed self-checking bench for take_arbiter
module tb_take_arbiter;
  import take_arbiter_pkg::*;

  localparam int NUM    = 2;
  localparam int DIN_W  = 16;
  localparam int CFG_W  = 16;
  localparam int IDX_W  = idx_width(NUM);
  localparam int DOUT_W = 1 + IDX_W + DIN_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [CFG_W-1:0]  cfg_data [NUM];
  logic [DIN_W:0]    din_data [NUM];
  logic [NUM-1:0]    cfg_valid, cfg_ready, din_valid, din_ready;
  logic [DOUT_W-1:0] dout_data;
  logic              dout_valid, dout_ready;

  dti #(.W(CFG_W))   cfg_if [NUM] ();
  dti #(.W(DIN_W+1)) din_if [NUM] ();
  dti #(.W(DOUT_W))  dout_if ();

  for (genvar i = 0; i < NUM; i++) begin : g_bind
    assign cfg_if[i].data  = cfg_data[i];
    assign cfg_if[i].valid = cfg_valid[i];
    assign cfg_ready[i]    = cfg_if[i].ready;
    assign din_if[i].data  = din_data[i];
    assign din_if[i].valid = din_valid[i];
    assign din_ready[i]    = din_if[i].ready;
  end
  assign dout_data     = dout_if.data;
  assign dout_valid    = dout_if.valid;
  assign dout_if.ready = dout_ready;

  take_arbiter #(.NUM(NUM), .DIN_W(DIN_W), .CFG_W(CFG_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .cfg  (cfg_if),
    .din  (din_if),
    .dout (dout_if)
  );

  logic [DIN_W:0]    src_q [NUM][$];
  logic [CFG_W-1:0]  cfgq  [NUM][$];
  logic [DOUT_W-1:0] out_log [$];
  int                out_cyc [$];
  int                pulses [NUM];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, drained, valid_seen, pulse_bad, stall_bad, comb_bad, pulse_cyc;
  logic              prev_stall;
  logic [DOUT_W-1:0] prev_data;
  logic [NUM-1:0]    hs_din, hs_cfg;
  bit                rand_ready = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DOUT_W-1:0] mk(input logic eot, input int idx, input int pay);
    dout_t d;
    d.eot     = eot;
    d.idx     = IDX_W'(idx);
    d.payload = DIN_W'(pay);
    return d;
  endfunction

  function automatic logic [DOUT_W-1:0] got_item(input int k);
    if (k < out_log.size()) return out_log[k];
    return '1;
  endfunction

  function automatic bit busy();
    for (int i = 0; i < NUM; i++)
      if (src_q[i].size() > 0 || cfgq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int i = 0; i < NUM; i++) begin
      din_valid[i] = (src_q[i].size() > 0);
      din_data[i]  = '0;
      if (din_valid[i]) din_data[i] = src_q[i][0];
      cfg_valid[i] = (cfgq[i].size() > 0);
      cfg_data[i]  = '0;
      if (cfg_valid[i]) cfg_data[i] = cfgq[i][0];
    end
    dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic push_txn(input int r, input int take, input int n, input int base);
    cfgq[r].push_back(CFG_W'(take));
    for (int k = 0; k < n; k++) src_q[r].push_back({(k == n - 1), DIN_W'(base + k)});
    drive();
  endtask

  task automatic clear_stats();
    out_log.delete();
    out_cyc.delete();
    drained = 0; valid_seen = 0; pulse_bad = 0; stall_bad = 0; comb_bad = 0;
    pulse_cyc = -1; prev_stall = 1'b0; prev_data = '0;
    for (int i = 0; i < NUM; i++) pulses[i] = 0;
  endtask

  // Sample at the falling edge, apply pops/new stimulus just after the rising edge.
  task automatic run_cycle();
    logic dhs;
    int   k;
    @(negedge clk);
    cyc++;
    dhs = dout_valid && dout_ready;
    if (dout_valid) valid_seen++;
    if (dhs) begin
      out_log.push_back(dout_data);
      out_cyc.push_back(cyc);
    end
    if (prev_stall && (!dout_valid || dout_data !== prev_data)) stall_bad++;
    prev_stall = dout_valid && !dout_ready;
    prev_data  = dout_data;
    if (dout_valid) begin
      k = int'(dout_data[DIN_W +: IDX_W]);
      if (din_ready[k] !== dout_ready || din_valid[k] !== 1'b1) comb_bad++;
    end
    for (int i = 0; i < NUM; i++) begin
      hs_din[i] = din_valid[i] && din_ready[i];
      hs_cfg[i] = cfg_valid[i] && cfg_ready[i];
      if (hs_din[i] && !dhs) drained++;
      if (cfg_ready[i]) begin
        pulses[i]++;
        pulse_cyc = cyc;
        if (!(hs_din[i] && din_data[i][DIN_W])) pulse_bad++;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM; i++) begin
      if (hs_din[i]) void'(src_q[i].pop_front());
      if (hs_cfg[i]) void'(cfgq[i].pop_front());
    end
    drive();
  endtask

  task automatic run_all(input string tag, input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      run_cycle();
      n++;
    end
    chk({tag, "_done"}, 64'(busy()), 64'd0);
    repeat (3) run_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n;
    int exp_pay [8] = '{'h300, 'h301, 'h310, 'h311, 'h302, 'h303, 'h312, 'h313};
    int exp_idx [8] = '{0, 0, 1, 1, 0, 0, 1, 1};

    clear_stats();
    drive();
    repeat (2) @(negedge clk);
    chk("rst_dout_valid", 64'(dout_valid), 64'd0);
    chk("rst_din_ready", 64'(din_ready), 64'd0);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Truncate a 5-item transaction to 3
    clear_stats();
    c0 = cyc;
    push_txn(0, 3, 5, 'h100);
    run_all("t1", 100);
    chk("t1_count", 64'(out_log.size()), 64'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("t1_item%0d", k), 64'(got_item(k)), 64'(mk(k == 2, 0, 'h100 + k)));
    chk("t1_latency", 64'(out_cyc.size() > 0 ? out_cyc[0] - c0 : -1), 64'd2);
    chk("t1_drained", 64'(drained), 64'd2);
    chk("t1_pulses", 64'(pulses[0]), 64'd1);
    chk("t1_pulse_eot", 64'(pulse_bad), 64'd0);

    // Source eot arrives before the take count
    clear_stats();
    push_txn(1, 8, 4, 'h200);
    run_all("t2", 100);
    chk("t2_count", 64'(out_log.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t2_item%0d", k), 64'(got_item(k)), 64'(mk(k == 3, 1, 'h200 + k)));
    chk("t2_pulses", 64'(pulses[1]), 64'd1);
    chk("t2_pulse_cyc", 64'(out_cyc.size() > 3 ? out_cyc[3] : -2), 64'(pulse_cyc));
    chk("t2_drained", 64'(drained), 64'd0);

    // Both requesters contend: alternate grants with one idle cycle between
    clear_stats();
    push_txn(0, 2, 2, 'h300);
    push_txn(1, 2, 2, 'h310);
    push_txn(0, 2, 2, 'h302);
    push_txn(1, 2, 2, 'h312);
    run_all("t3", 200);
    chk("t3_count", 64'(out_log.size()), 64'd8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("t3_item%0d", k), 64'(got_item(k)), 64'(mk(k % 2 == 1, exp_idx[k], exp_pay[k])));
    for (int k = 1; k < 8; k++)
      chk($sformatf("t3_gap%0d", k),
          64'(out_cyc.size() > k ? out_cyc[k] - out_cyc[k-1] : -1), 64'((k % 2 == 1) ? 1 : 2));
    chk("t3_pulses0", 64'(pulses[0]), 64'd2);
    chk("t3_pulses1", 64'(pulses[1]), 64'd2);

    // Zero take count: whole transaction drained
    clear_stats();
    push_txn(0, 0, 3, 'h400);
    run_all("t4", 100);
    chk("t4_valid_seen", 64'(valid_seen), 64'd0);
    chk("t4_drained", 64'(drained), 64'd3);
    chk("t4_pulses", 64'(pulses[0]), 64'd1);
    chk("t4_pulse_eot", 64'(pulse_bad), 64'd0);

    // Random backpressure
    clear_stats();
    rand_ready = 1;
    push_txn(1, 4, 6, 'h500);
    push_txn(1, 4, 6, 'h510);
    run_all("t5", 400);
    rand_ready = 0;
    drive();
    chk("t5_count", 64'(out_log.size()), 64'd8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("t5_item%0d", k), 64'(got_item(k)),
          64'(mk(k % 4 == 3, 1, (k < 4) ? 'h500 + k : 'h510 + k - 4)));
    chk("t5_drained", 64'(drained), 64'd4);
    chk("t5_stall_stable", 64'(stall_bad), 64'd0);
    chk("t5_comb_ready", 64'(comb_bad), 64'd0);
    chk("t5_pulses", 64'(pulses[1]), 64'd2);

    // Asynchronous reset in the middle of PASS
    clear_stats();
    push_txn(0, 5, 6, 'h600);
    n = 0;
    while (out_log.size() < 2 && n < 50) begin
      run_cycle();
      n++;
    end
    chk("t6_two_items", 64'(out_log.size()), 64'd2);
    #2;
    chk("t6_pre_valid", 64'(dout_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(dout_valid), 64'd0);
    chk("t6_rst_din_ready", 64'(din_ready), 64'd0);
    for (int i = 0; i < NUM; i++) begin
      src_q[i].delete();
      cfgq[i].delete();
    end
    drive();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_stats();
    push_txn(0, 1, 1, 'h700);
    push_txn(1, 1, 1, 'h710);
    run_all("t6", 100);
    chk("t6_count", 64'(out_log.size()), 64'd2);
    chk("t6_first", 64'(got_item(0)), 64'(mk(1, 0, 'h700)));
    chk("t6_second", 64'(got_item(1)), 64'(mk(1, 1, 'h710)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
